flag_setting_unit: RTL
======================

Name: flag_setting_unit

Overview:
- Upstream neighbour of the conditional unit. Holds the architectural NZCV flag register.
- Commits ALU flags from the execute stage under per-group write enables, gated by the condition-passed result.
- Presents the current flags (ALUFlags format) to the conditional unit.
- Provides a one-deep shadow copy for exception entry and return, with a two-state FSM and sticky error reporting.

Parameters:
- FLAG_W, 4, flag vector width; bit order [3]=N, [2]=Z, [1]=C, [0]=V.
- RESET_FLAGS, 4'b0000, value loaded into the flag and shadow registers on reset.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-low; sampled on the clk rising edge.
- alu_flags  input  FLAG_W  NZCV produced by the ALU for the instruction in execute.
- alu_valid  input  1  execute stage holds a valid instruction.
- flag_w  input  2  [1]=update N,Z; [0]=update C,V.
- cond_ex  input  1  condition-passed from the conditional unit for the instruction in execute.
- stall  input  1  execute stage held; no commit this cycle.
- flush  input  1  execute instruction squashed; no commit this cycle.
- save  input  1  exception entry pulse.
- restore  input  1  exception return pulse.
- flags_out  output  FLAG_W  flags to the conditional unit (ALUFlags).
- in_exc  output  1  FSM is in EXC.
- seq_err  output  1  sticky sequencing-error flag.

Behaviour:
- Reset (rst==0 at a posedge):
  - flags and shadow <= RESET_FLAGS.
  - FSM <= NORMAL, in_exc=0, seq_err=0.
  - Reset overrides every other input in that cycle.
  - A reset asserted mid-exception discards the shadow.
- Commit qualifier: commit = alu_valid & cond_ex & ~stall & ~flush.
- Flag updates when commit is true:
  - flags[3:2] <= alu_flags[3:2] when flag_w[1]=1.
  - flags[1:0] <= alu_flags[1:0] when flag_w[0]=1.
  - Groups update independently. flag_w=00 leaves both groups unchanged.
- Commit latency: one cycle. The commit is visible on flags_out the cycle after the edge (registered path).
- FSM states: NORMAL, EXC.
- NORMAL & save:
  - shadow <= next_flags, i.e. the flags including any same-cycle commit.
  - FSM -> EXC, in_exc=1 the next cycle.
- EXC & restore:
  - flags <= shadow. This overrides any same-cycle ALU commit; the commit is dropped.
  - FSM -> NORMAL.
- EXC & save: ignored, shadow kept; seq_err <= 1 (nesting not supported).
- NORMAL & restore: ignored, flags still take any commit; seq_err <= 1.
- save & restore in the same cycle:
  - In NORMAL: treated as save, and seq_err <= 1.
  - In EXC: treated as restore, and seq_err <= 1.
- seq_err is cleared only by reset.
- stall or flush blocks ALU commits only; save and restore still act.
- Commits continue in EXC (handler code sets flags); only the shadow is frozen.

Optional Feature:
- Macro: FLAG_SETTING_BYPASS_EN.
- Defined:
  - flags_out is combinational next_flags, i.e. the value the flag register will hold after the current edge (commit or restore applied).
  - A dependent condition check sees the new flags with zero latency.
- Undefined:
  - flags_out equals the flag register.
  - Consumers see an update one cycle after the commit edge.
- Reset value and all state behaviour are identical in both builds.

Decomposition:
- Shared package (e.g. pda_pkg):
  - typedef nzcv_t, a 4-bit packed struct {n, z, c, v}.
  - Index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - Enum exc_state_t {NORMAL, EXC}.
  - Constant RESET_FLAGS default.
- One natural sub-module: flag_next_logic.
  - Combinational mux computing next_flags from flags, shadow, commit, flag_w and restore.
  - Shared by the register path and the FLAG_SETTING_BYPASS_EN output path.

Test Plan:
1. Reset held low 2 cycles with alu_flags=1111, alu_valid=1, cond_ex=1, flag_w=11 -> flags_out=0000, in_exc=0, seq_err=0. Release reset -> flags_out=1111 one cycle later (non-bypass build).
2. flags=0000; commit alu_flags=1010 with flag_w=10 -> flags_out=1000. Then alu_flags=0101 with flag_w=01 -> flags_out=1001.
3. flags=1001; alu_flags=0110, flag_w=11, alu_valid=1, with cond_ex=0, then stall=1, then flush=1 (one cycle each) -> flags_out stays 1001 throughout.
4. flags=0100; save together with commit alu_flags=0010, flag_w=11 -> in_exc=1, flags_out=0010. Commit 1100 -> flags_out=1100. Restore together with commit 0001 -> flags_out=0010, in_exc=0, seq_err=0.
5. In EXC, a second save, then restore, then restore again in NORMAL -> shadow unchanged by the second save; after the first restore flags equal the original shadow; seq_err=1 from the first error onward and remains 1 until rst=0.
6. Bypass build (FLAG_SETTING_BYPASS_EN defined): commit alu_flags=0100, flag_w=10 -> flags_out=0100 in the same cycle the inputs are applied. Non-bypass build -> 0100 only after the edge.

Source files
------------

// File: rtl/flag_setting_unit_pkg.sv
// Shared types and constants for the NZCV flag-setting unit.
// Bit order of every flag vector: [3]=N, [2]=Z, [1]=C, [0]=V.
package flag_setting_unit_pkg;

    // Packed view of the architectural flags, MSB first.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    // Bit positions inside a flag vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Exception sequencing states: one-deep shadow only, no nesting.
    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        EXC    = 1'b1
    } exc_state_t;

    // Value loaded into the flag and shadow registers on reset.
    localparam logic [3:0] RESET_FLAGS_DEFAULT = 4'b0000;

endpackage

// File: rtl/flag_next_logic.sv
// Combinational next-value mux for the flag register.
// A taken restore wins over any ALU commit; otherwise the N,Z and C,V groups
// are replaced independently under their own write enables.
module flag_next_logic
    import flag_setting_unit_pkg::*;
#(
    parameter int FLAG_W = 4
) (
    input  logic [FLAG_W-1:0] flags,
    input  logic [FLAG_W-1:0] shadow,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic              commit,
    input  logic [1:0]        flag_w,
    input  logic              restore,
    output logic [FLAG_W-1:0] next_flags
);

    // Select restore source, else merge committed groups into current flags.
    always_comb begin
        next_flags = flags;
        if (restore) begin
            next_flags = shadow;
        end else if (commit) begin
            if (flag_w[1]) begin
                next_flags[FLAG_N:FLAG_Z] = alu_flags[FLAG_N:FLAG_Z];
            end
            if (flag_w[0]) begin
                next_flags[FLAG_C:FLAG_V] = alu_flags[FLAG_C:FLAG_V];
            end
        end
    end

endmodule

// File: rtl/flag_setting_unit.sv
// Architectural NZCV flag register with a one-deep exception shadow.
// Optional build macro FLAG_SETTING_BYPASS_EN: when defined, flags_out shows
// the value the flag register will hold after the current edge (zero-latency
// forwarding); when undefined, flags_out is the flag register itself.
// Sequencing errors (save while in EXC, restore while in NORMAL) are sticky
// until reset.
module flag_setting_unit
    import flag_setting_unit_pkg::*;
#(
    parameter int               FLAG_W      = 4,
    parameter logic [FLAG_W-1:0] RESET_FLAGS = RESET_FLAGS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic              alu_valid,
    input  logic [1:0]        flag_w,
    input  logic              cond_ex,
    input  logic              stall,
    input  logic              flush,
    input  logic              save,
    input  logic              restore,
    output logic [FLAG_W-1:0] flags_out,
    output logic              in_exc,
    output logic              seq_err
);

    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] shadow_q;
    logic [FLAG_W-1:0] next_flags;
    logic              seq_err_q;
    exc_state_t        state_q;
    exc_state_t        state_d;

    logic commit;
    logic do_save;
    logic do_restore;
    logic bad_seq;

    // Qualify the ALU commit and decode the exception controls against state.
    always_comb begin
        commit     = alu_valid & cond_ex & ~stall & ~flush;
        do_save    = (state_q == NORMAL) & save;
        do_restore = (state_q == EXC) & restore;
        bad_seq    = ((state_q == EXC) & save) | ((state_q == NORMAL) & restore);
    end

    flag_next_logic #(
        .FLAG_W (FLAG_W)
    ) u_next (
        .flags      (flags_q),
        .shadow     (shadow_q),
        .alu_flags  (alu_flags),
        .commit     (commit),
        .flag_w     (flag_w),
        .restore    (do_restore),
        .next_flags (next_flags)
    );

    // Flag, shadow and sticky-error registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            flags_q   <= RESET_FLAGS;
            shadow_q  <= RESET_FLAGS;
            seq_err_q <= 1'b0;
        end else begin
            flags_q <= next_flags;
            if (do_save) begin
                shadow_q <= next_flags;
            end
            if (bad_seq) begin
                seq_err_q <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: save enters EXC from NORMAL, restore leaves it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            NORMAL:  if (save)    state_d = EXC;
            EXC:     if (restore) state_d = NORMAL;
            default: state_d = NORMAL;
        endcase
    end

    // FSM outputs and flag presentation to the conditional unit.
    always_comb begin
        in_exc  = (state_q == EXC);
        seq_err = seq_err_q;
`ifdef FLAG_SETTING_BYPASS_EN
        flags_out = rst ? next_flags : RESET_FLAGS;
`else
        flags_out = flags_q;
`endif
    end

endmodule
